// File: rtl/led_pattern_controller_if.sv
// Control/config inputs and LED-side outputs of the LED pattern sequencer.
// The controller connects as slave; the driving side connects as master.
interface led_pattern_controller_if #(
    parameter int N_LED = 4,
    parameter int DIV_W = 16
);
    logic             cfg_wr;
    logic [1:0]       cfg_mode;
    logic [DIV_W-1:0] cfg_div;
    logic             enable;
    logic             step;
    logic [N_LED-1:0] led;
    logic             tick;
    logic [1:0]       state;

    modport master (
        output cfg_wr, cfg_mode, cfg_div, enable, step,
        input  led, tick, state
    );

    modport slave (
        input  cfg_wr, cfg_mode, cfg_div, enable, step,
        output led, tick, state
    );
endinterface

// File: rtl/led_pattern_controller.sv
// Running-light sequencer for the LED bank: rotate/bounce/blink patterns,
// prescaled step rate, run/hold/single-step control.
//
// state  | meaning
// IDLE   | after reset, LEDs dark, waits for enable
// RUN    | prescaler counts, pattern advances when cnt reaches div
// HOLD   | pattern and prescaler frozen, step strobe advances once
module led_pattern_controller #(
    parameter int N_LED       = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    led_pattern_controller_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    localparam logic [1:0] M_ROTL   = 2'd0;
    localparam logic [1:0] M_ROTR   = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;

    state_t           r_state, w_state_nxt;
    logic [N_LED-1:0] r_led, w_led_nxt, w_adv_led;
    logic             r_tick, w_tick_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_dir, w_dir_nxt, w_adv_dir;

    function automatic logic [N_LED-1:0] f_seed(input logic [1:0] mode);
        logic [N_LED-1:0] one_hot;
        one_hot = '0;
        one_hot[0] = 1'b1;
        return (mode == 2'd3) ? {N_LED{1'b1}} : one_hot;
    endfunction

    // Next pattern value; r_dir=1 means moving toward the MSB.
    always_comb begin
        w_adv_led = r_led;
        w_adv_dir = r_dir;
        case (r_mode)
            M_ROTL: w_adv_led = {r_led[N_LED-2:0], r_led[N_LED-1]};
            M_ROTR: w_adv_led = {r_led[0], r_led[N_LED-1:1]};
            M_BOUNCE: begin
                if (r_dir) begin
                    if (r_led[N_LED-1]) begin
                        w_adv_led = r_led >> 1;
                        w_adv_dir = 1'b0;
                    end else begin
                        w_adv_led = r_led << 1;
                    end
                end else begin
                    if (r_led[0]) begin
                        w_adv_led = r_led << 1;
                        w_adv_dir = 1'b1;
                    end else begin
                        w_adv_led = r_led >> 1;
                    end
                end
            end
            default: w_adv_led = ~r_led;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_tick_nxt  = 1'b0;
        w_mode_nxt  = r_mode;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;

        if (bus.cfg_wr) begin
            w_mode_nxt = bus.cfg_mode;
            w_div_nxt  = bus.cfg_div;
            if (r_state != S_IDLE) begin
                w_led_nxt = f_seed(bus.cfg_mode);
                w_cnt_nxt = '0;
                w_dir_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_led_nxt = '0;
                    if (bus.enable) begin
                        w_state_nxt = S_RUN;
                        w_led_nxt   = f_seed(r_mode);
                        w_cnt_nxt   = '0;
                        w_dir_nxt   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!bus.enable) begin
                        w_state_nxt = S_HOLD;
                    end else if (r_cnt >= r_div) begin
                        w_led_nxt  = w_adv_led;
                        w_dir_nxt  = w_adv_dir;
                        w_cnt_nxt  = '0;
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + DIV_W'(1);
                    end
                end
                S_HOLD: begin
                    // enable wins over a coincident step strobe
                    if (bus.enable) begin
                        w_state_nxt = S_RUN;
                    end else if (bus.step) begin
                        w_led_nxt  = w_adv_led;
                        w_dir_nxt  = w_adv_dir;
                        w_tick_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_tick  <= 1'b0;
            r_mode  <= 2'd0;
            r_div   <= DIV_W'(DEFAULT_DIV);
            r_cnt   <= '0;
            r_dir   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= w_led_nxt;
            r_tick  <= w_tick_nxt;
            r_mode  <= w_mode_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    assign bus.led   = r_led;
    assign bus.tick  = r_tick;
    assign bus.state = r_state;

endmodule
